// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Two byte requesters share one UART transmit pin. Source 0 is the FIR result
// path and source 1 is the status/echo path. A round-robin arbiter picks one
// requester, latches its byte and acknowledges it. The byte is then sent on
// txd as a frame: start bit, data bits LSB first, an optional parity bit, and
// one or two stop bits.
//
// The block also controls an external baud tick generator (oversampling 1).
// While idle, that generator is held cleared. During a frame it runs freely,
// and each baud_tick it produces advances the frame by one bit.
//
// Parameters
//   DATA_BITS   data bits per frame, LSB first (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
//   PARITY_EN   1 = insert a parity bit after the data bits
//   PARITY_ODD  1 = odd parity, 0 = even parity (only with PARITY_EN = 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   req0/data0  source 0 request level and byte; held until ack0
//   ack0        1-cycle pulse: data0 latched
//   req1/data1  source 1 request level and byte; held until ack1
//   ack1        1-cycle pulse: data1 latched
//   baud_tick   1-cycle bit strobe from the tick generator
//   baud_rst_n  tick generator reset; 0 holds its counter cleared
//   baud_en     tick generator enable
//   txd         serial line, idles high, registered
//   busy        high whenever a frame is in progress
//   last_src    source of the most recently granted byte
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [DATA_BITS-1:0] data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [DATA_BITS-1:0] data1,
    output logic                 ack1,
    input  logic                 baud_tick,
    output logic                 baud_rst_n,
    output logic                 baud_en,
    output logic                 txd,
    output logic                 busy,
    output logic                 last_src
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_reg,    state_next;
    logic [DATA_BITS-1:0]   shift_reg,    shift_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg,  bit_cnt_next;
    logic [1:0]             stop_cnt_reg, stop_cnt_next;
    logic                   parity_reg,   parity_next;
    logic                   txd_reg,      txd_next;
    logic                   ack0_reg,     ack0_next;
    logic                   ack1_reg,     ack1_next;
    logic                   last_src_reg, last_src_next;

    // -------------------------------------------------------------------------
    // Arbitration.
    // A lone requester always wins. When both sources request, the grant goes
    // to the source that was not served last. last_src resets to 1, so the
    // first contested grant after reset goes to source 0.
    // -------------------------------------------------------------------------
    logic                 any_req;
    logic                 winner;
    logic [DATA_BITS-1:0] win_data;
    logic                 win_parity;

    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? ~last_src_reg : req1;

    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_win_data
        assign win_data[gi] = winner ? data1[gi] : data0[gi];
    end

    // For even parity the parity bit equals the XOR of the data bits; odd
    // parity inverts that bit. The bit is computed once, when the byte is
    // latched, because the shift register no longer holds the whole byte by
    // the time the parity bit is sent.
    assign win_parity = (^win_data) ^ (PARITY_ODD != 0);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic.
    // txd_next holds the line level for the state being entered. txd is
    // therefore a clean registered output and changes one cycle after the
    // tick that caused the transition.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;
        txd_next      = txd_reg;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        last_src_next = last_src_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // baud_tick is ignored here: the generator is held cleared.
                txd_next = 1'b1;
                if (any_req) begin
                    shift_next    = win_data;
                    parity_next   = win_parity;
                    last_src_next = winner;
                    ack0_next     = ~winner;
                    ack1_next     = winner;
                    txd_next      = 1'b0;
                    state_next    = ST_START;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    bit_cnt_next = '0;
                    txd_next     = shift_reg[0];
                    state_next   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
                    if (bit_cnt_reg == BIT_CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            txd_next   = parity_reg;
                            state_next = ST_PARITY;
                        end else begin
                            stop_cnt_next = '0;
                            txd_next      = 1'b1;
                            state_next    = ST_STOP;
                        end
                    end else begin
                        // The shift happens on this same edge, so the next
                        // bit on the line is the current bit 1.
                        txd_next = shift_reg[1];
                    end
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    stop_cnt_next = '0;
                    txd_next      = 1'b1;
                    state_next    = ST_STOP;
                end
            end

            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_reg == 2'(STOP_BITS - 1)) begin
                        txd_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 2'd1;
                    end
                end
            end

            default: begin
                txd_next   = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. A reset aborts any frame in progress and issues no ack.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            parity_reg   <= 1'b0;
            txd_reg      <= 1'b1;
            ack0_reg     <= 1'b0;
            ack1_reg     <= 1'b0;
            last_src_reg <= 1'b1;
        end else begin
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            txd_reg      <= txd_next;
            ack0_reg     <= ack0_next;
            ack1_reg     <= ack1_next;
            last_src_reg <= last_src_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // busy and the tick-generator controls decode directly from the state
    // register. As a result, an asynchronous reset clears them at once,
    // without waiting for a clock edge.
    // -------------------------------------------------------------------------
    assign busy       = (state_reg != ST_IDLE);
    assign baud_en    = busy;
    assign baud_rst_n = busy;
    assign txd        = txd_reg;
    assign ack0       = ack0_reg;
    assign ack1       = ack1_reg;
    assign last_src   = last_src_reg;

    // -------------------------------------------------------------------------
    // Design invariants.
    // -------------------------------------------------------------------------
    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(ack0_reg && ack1_reg));

    a_ack_single_cycle: assert property (@(posedge clk) disable iff (!rst)
        (ack0_reg || ack1_reg) |=> !(ack0_reg || ack1_reg));

    a_idle_line_high: assert property (@(posedge clk) disable iff (!rst)
        (state_reg == ST_IDLE) |-> txd_reg);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_scheduler.
//
// Three instances share one clock and reset:
//   inst 0: 8 data bits, no parity, 1 stop bit
//   inst 1: 8 data bits, even parity, 1 stop bit
//   inst 2: 8 data bits, odd parity, 2 stop bits
//
// Each instance has its own behavioural tick generator with a 4-clk bit
// period. Expected frames come from a table of hand-computed values, or from
// a frame model built from the line format.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NI  = 3;
    localparam int DIV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     req0_v;
    logic [NI-1:0]     req1_v;
    logic [NI-1:0]     tick_force;
    logic [7:0]        data0_v [NI];
    logic [7:0]        data1_v [NI];
    wire  [NI-1:0]     ack0_w;
    wire  [NI-1:0]     ack1_w;
    wire  [NI-1:0]     brst_w;
    wire  [NI-1:0]     ben_w;
    wire  [NI-1:0]     txd_w;
    wire  [NI-1:0]     busy_w;
    wire  [NI-1:0]     last_w;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit exp_last [NI];

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUT instances, each with its own tick generator.
    // tick_force injects extra ticks for the idle test.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [1:0] cnt;
        wire        tick;

        always @(posedge clk) begin
            if (!brst_w[gi])     cnt <= 2'd0;
            else if (ben_w[gi])  cnt <= cnt + 2'd1;
        end

        assign tick = (brst_w[gi] & ben_w[gi] & (cnt == 2'(DIV - 1))) | tick_force[gi];

        uart_tx_scheduler #(
            .DATA_BITS (8),
            .STOP_BITS ((gi == 2) ? 2 : 1),
            .PARITY_EN ((gi != 0) ? 1 : 0),
            .PARITY_ODD((gi == 2) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req0      (req0_v[gi]),
            .data0     (data0_v[gi]),
            .ack0      (ack0_w[gi]),
            .req1      (req1_v[gi]),
            .data1     (data1_v[gi]),
            .ack1      (ack1_w[gi]),
            .baud_tick (tick),
            .baud_rst_n(brst_w[gi]),
            .baud_en   (ben_w[gi]),
            .txd       (txd_w[gi]),
            .busy      (busy_w[gi]),
            .last_src  (last_w[gi])
        );
    end

    // -------------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, k, got, exp);
        end
    endtask

    // Reference frame built from the line format: start bit 0, data LSB
    // first, optional parity bit, then stop bits at 1. Bit i is the i-th bit
    // on the line.
    function automatic void frame_model(input int k, input logic [7:0] b,
                                        output logic [11:0] bits, output int len);
        int n;
        bits = '0;
        n    = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = b[i];
            n++;
        end
        if (k != 0) begin
            bits[n] = (($countones(b) % 2) == 1) ^ (k == 2);
            n++;
        end
        for (int s = 0; s < ((k == 2) ? 2 : 1); s++) begin
            bits[n] = 1'b1;
            n++;
        end
        len = n;
    endfunction

    // Waits (bounded) for an ack, then checks its source and last_src.
    // drop: 0 keep requests, 1 drop only the acked request, 2 drop both.
    task automatic grant_check(input int k, input int exp_src, input int drop,
                               output int waited);
        bit seen = 1'b0;
        waited = 0;
        while (!seen && waited < 64) begin
            @(negedge clk);
            waited++;
            seen = ack0_w[k] | ack1_w[k];
        end
        chk("ack_seen", k, 32'(seen), 32'd1);
        if (!seen) return;
        chk("ack_src", k, 32'({ack1_w[k], ack0_w[k]}), (exp_src != 0) ? 32'd2 : 32'd1);
        chk("last_src", k, 32'(last_w[k]), 32'(exp_src));
        exp_last[k] = (exp_src != 0);
        if (drop == 2) begin
            req0_v[k] = 1'b0;
            req1_v[k] = 1'b0;
        end else if (drop == 1) begin
            if (exp_src != 0) req1_v[k] = 1'b0;
            else              req0_v[k] = 1'b0;
        end
    endtask

    // Checks the whole frame, starting at the ack negedge, then the idle
    // state one cycle after the final stop tick.
    task automatic body_check(input int k, input logic [11:0] bits, input int len,
                              input logic [7:0] b);
        logic [11:0] got     = '0;
        bit          bad_txd = 1'b0;
        bit          bad_ctl = 1'b0;
        for (int c = 0; c < len * DIV; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % DIV) == DIV / 2) got[c / DIV] = txd_w[k];
            if (txd_w[k] !== bits[c / DIV]) bad_txd = 1'b1;
            if (busy_w[k] !== 1'b1 || ben_w[k] !== 1'b1 || brst_w[k] !== 1'b1) bad_ctl = 1'b1;
            if (c > 0 && (ack0_w[k] | ack1_w[k])) bad_ctl = 1'b1;
        end
        vec_cnt++;
        if (bad_txd) begin
            miss_cnt++;
            $display("FAIL frame_bits inst=%0d byte=%02h got=%03h want=%03h", k, b, got, bits);
        end
        chk("frame_ctl", k, 32'(bad_ctl), 32'd0);
        @(negedge clk);
        chk("end_idle", k, 32'({busy_w[k], ben_w[k], brst_w[k], txd_w[k]}), 32'b0001);
        $display("frame inst=%0d byte=%02h bits=%03h len=%0d", k, b, got, len);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    typedef struct {
        int          inst;
        bit          r0;
        bit          r1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          src;
        logic [11:0] bits;
        int          len;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        int          w;
        int          k;
        int          pat;
        int          src;
        int          fl;
        logic [11:0] fb;
        logic [7:0]  b;
        bit          bad;

        tbl[0] = '{0, 1'b1, 1'b0, 8'hA5, 8'h00, 0, 12'h34A, 10};
        tbl[1] = '{0, 1'b0, 1'b1, 8'h00, 8'h3C, 1, 12'h278, 10};
        tbl[2] = '{1, 1'b1, 1'b0, 8'h07, 8'h00, 0, 12'h60E, 11};
        tbl[3] = '{2, 1'b0, 1'b1, 8'h00, 8'h07, 1, 12'hC0E, 12};
        tbl[4] = '{0, 1'b1, 1'b1, 8'hFF, 8'h00, 0, 12'h3FE, 10};
        tbl[5] = '{2, 1'b1, 1'b1, 8'h80, 8'h01, 0, 12'hD00, 12};

        rst        = 1'b0;
        req0_v     = '0;
        req1_v     = '0;
        tick_force = '0;
        for (int i = 0; i < NI; i++) begin
            data0_v[i]  = 8'h00;
            data1_v[i]  = 8'h00;
            exp_last[i] = 1'b1;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk("rst_state", i,
                32'({txd_w[i], busy_w[i], ben_w[i], brst_w[i], ack0_w[i], ack1_w[i], last_w[i]}),
                32'b1000001);
        rst = 1'b1;

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            k          = tbl[i].inst;
            data0_v[k] = tbl[i].d0;
            data1_v[k] = tbl[i].d1;
            req0_v[k]  = tbl[i].r0;
            req1_v[k]  = tbl[i].r1;
            grant_check(k, tbl[i].src, 2, w);
            chk("grant_latency", k, 32'(w), 32'd1);
            body_check(k, tbl[i].bits, tbl[i].len, (tbl[i].src != 0) ? tbl[i].d1 : tbl[i].d0);
        end

        // Idle: an injected tick is ignored, and a request dropped before the
        // grant edge is never acked.
        @(negedge clk);
        tick_force[0] = 1'b1;
        @(negedge clk);
        tick_force[0] = 1'b0;
        req0_v[0]     = 1'b1;
        data0_v[0]    = 8'h5A;
        #2 req0_v[0]  = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack0_w[0] | ack1_w[0] | busy_w[0] | ~txd_w[0]) bad = 1'b1;
        end
        chk("idle_ignore", 0, 32'(bad), 32'd0);
        $display("idle tick + short req inst=0 checked");

        // Two stop bits, with req1 raised mid-frame. req1 is granted one clk
        // after entering IDLE.
        req0_v[2]  = 1'b1;
        data0_v[2] = 8'h5A;
        grant_check(2, 0, 1, w);
        req1_v[2]  = 1'b1;
        data1_v[2] = 8'hC3;
        frame_model(2, 8'h5A, fb, fl);
        body_check(2, fb, fl, 8'h5A);
        grant_check(2, 1, 1, w);
        chk("pending_gap", 2, 32'(w), 32'd1);
        frame_model(2, 8'hC3, fb, fl);
        body_check(2, fb, fl, 8'hC3);

        // Reset during the 4th data bit, then a complete frame afterwards.
        req0_v[0]  = 1'b1;
        data0_v[0] = 8'hA5;
        grant_check(0, 0, 1, w);
        repeat (17) @(negedge clk);
        chk("pre_abort_txd", 0, 32'(txd_w[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort", 0,
            32'({txd_w[0], busy_w[0], brst_w[0], ben_w[0], ack0_w[0], ack1_w[0], last_w[0]}),
            32'b1000001);
        for (int i = 0; i < NI; i++) exp_last[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req1_v[0]  = 1'b1;
        data1_v[0] = 8'h3C;
        rst        = 1'b1;
        grant_check(0, 1, 1, w);
        chk("post_abort_latency", 0, 32'(w), 32'd1);
        body_check(0, 12'h278, 10, 8'h3C);

        // Both sources request continuously from reset. Grants alternate
        // 0, 1, 0.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) exp_last[i] = 1'b1;
        req0_v[0]  = 1'b1;
        req1_v[0]  = 1'b1;
        data0_v[0] = 8'h11;
        data1_v[0] = 8'h22;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int f = 0; f < 3; f++) begin
            src = f % 2;
            grant_check(0, src, 0, w);
            chk("rr_gap", 0, 32'(w), 32'd1);
            b = (src != 0) ? 8'h22 : 8'h11;
            frame_model(0, b, fb, fl);
            body_check(0, fb, fl, b);
        end
        req0_v[0] = 1'b0;
        req1_v[0] = 1'b0;
        @(negedge clk);
        chk("rr_stop", 0, 32'({ack0_w[0], ack1_w[0], busy_w[0]}), 32'd0);

        // Random traffic against the model.
        for (int r = 0; r < 30; r++) begin
            k          = int'($urandom_range(0, NI - 1));
            pat        = int'($urandom_range(1, 3));
            data0_v[k] = 8'($urandom);
            data1_v[k] = 8'($urandom);
            req0_v[k]  = (pat & 1) != 0;
            req1_v[k]  = (pat & 2) != 0;
            if (pat == 1)      src = 0;
            else if (pat == 2) src = 1;
            else               src = exp_last[k] ? 0 : 1;
            b = (src != 0) ? data1_v[k] : data0_v[k];
            frame_model(k, b, fb, fl);
            grant_check(k, src, 2, w);
            chk("grant_latency", k, 32'(w), 32'd1);
            body_check(k, fb, fl, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
